// File: rtl/chase_pkg.sv
// Shared types and constants for the chasebot drive controller.
package chase_pkg;

    localparam int PWM_W         = 8;
    localparam int SCREEN_CENTER = 512;

    typedef enum logic [2:0] {
        ST_STOP   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_TURN_L = 3'd2,
        ST_TURN_R = 3'd3,
        ST_FWD    = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    typedef struct packed {
        logic [PWM_W-1:0] duty;
        logic             dir;
    } drive_t;

    function automatic drive_t mk_drive(input logic [PWM_W-1:0] duty, input logic dir);
        drive_t d;
        d.duty = duty;
        d.dir  = dir;
        return d;
    endfunction

endpackage

// File: rtl/chase_drive_pwm_gen.sv
// One motor channel: prescaled 8-bit ramp, wrap-aligned duty commit and registered compare.
module pwm_gen
    import chase_pkg::*;
#(
    parameter int PWM_DIV = 254
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   sync_clear,
    input  drive_t req,
    output logic   pwm,
    output logic   dir
);

    localparam int            PW       = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(PWM_DIV);

    logic [PW-1:0]    presc_q, presc_d;
    logic [PWM_W-1:0] ramp_q, ramp_d;
    drive_t           pending_q, pending_d;
    drive_t           active_q, active_d;
    logic             pwm_q, pwm_d;
    logic             step_s, wrap_s;

    // Next-state: the wrap commits whatever was pending before this edge; clear bypasses the wrap.
    always_comb begin
        step_s    = (presc_q == PRESC_TC);
        wrap_s    = step_s && (ramp_q == 8'hFF);
        presc_d   = step_s ? '0 : presc_q + PW'(1);
        ramp_d    = step_s ? ramp_q + 8'd1 : ramp_q;
        if (sync_clear) begin
            pending_d = mk_drive(8'd0, 1'b1);
            active_d  = mk_drive(8'd0, 1'b1);
            pwm_d     = 1'b0;
        end else begin
            pending_d = req;
            active_d  = wrap_s ? pending_q : active_q;
            pwm_d     = (ramp_q < active_q.duty);
        end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            ramp_q    <= 8'd0;
            pending_q <= '0;
            active_q  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            ramp_q    <= ramp_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm = pwm_q;
    assign dir = active_q.dir;

endmodule

// File: rtl/chase_drive.sv
// Chasebot steering: samples the tracker's centroid at each frame end and drives two PWM motors.
module chase_drive
    import chase_pkg::*;
#(
    parameter int IMG_WIDTH   = 1024,
    parameter int DEADBAND    = 64,
    parameter int R_MIN       = 4,
    parameter int R_NEAR      = 80,
    parameter int LOST_FRAMES = 15,
    parameter int SEARCH_DUTY = 96,
    parameter int TURN_DUTY   = 128,
    parameter int FWD_DUTY    = 224,
    parameter int PWM_DIV     = 254
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic [31:0] x_center,
    input  logic [23:0] radius,
    input  logic        enable,
    output logic        left_pwm,
    output logic        right_pwm,
    output logic        left_dir,
    output logic        right_dir,
    output logic [2:0]  state,
    output logic        frame_tick
);

    localparam int                LOST_W  = $clog2(LOST_FRAMES + 1);
    localparam logic [LOST_W-1:0] LOST_TC = LOST_W'(LOST_FRAMES);

    logic              vs_meta_q, vs_sync_q, vs_prev_q;
    logic              tick_q, tick_d;
    logic [10:0]       x_q, x_d;
    logic [23:0]       r_q, r_d;
    logic              ok_q, ok_d;
    logic              half_q, half_d;
    logic [LOST_W-1:0] lost_q, lost_d, lost_inc_s;
    state_t            state_q, state_d;
    logic              fall_s, blob_ok_s;
    logic [7:0]        fwd_duty_s;
    drive_t            left_req_s, right_req_s;

    // Frame sampling, lost counter and mode decision (decided once, in the frame_tick cycle).
    always_comb begin
        fall_s     = vs_prev_q & ~vs_sync_q;
        blob_ok_s  = (radius >= 24'(R_MIN)) && (x_center < 32'(IMG_WIDTH));
        tick_d     = fall_s;
        x_d        = fall_s ? x_center[10:0] : x_q;
        r_d        = fall_s ? radius : r_q;
        ok_d       = fall_s ? blob_ok_s : ok_q;
        lost_inc_s = (lost_q == LOST_TC) ? lost_q : lost_q + LOST_W'(1);
        lost_d     = lost_q;
        half_d     = half_q;
        state_d    = state_q;
        if (tick_q) begin
            lost_d = ok_q ? '0 : lost_inc_s;
            half_d = (r_q >= 24'(R_NEAR / 2));
            if (ok_q) begin
                if (r_q >= 24'(R_NEAR)) begin
                    state_d = ST_HOLD;
                end else if (x_q < 11'(SCREEN_CENTER - DEADBAND)) begin
                    state_d = ST_TURN_L;
                end else if (x_q > 11'(SCREEN_CENTER - 1 + DEADBAND)) begin
                    state_d = ST_TURN_R;
                end else begin
                    state_d = ST_FWD;
                end
            end else if (lost_inc_s == LOST_TC) begin
                state_d = ST_SEARCH;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
        if (!enable) begin
            state_d = ST_STOP;
        end else begin
            state_d = state_d;
        end
    end

    // Drive map from the registered mode; the pwm channels register it as pending.
    always_comb begin
        fwd_duty_s = half_q ? 8'(FWD_DUTY >> 1) : 8'(FWD_DUTY);
        case (state_q)
            ST_SEARCH: begin
                left_req_s  = mk_drive(8'(SEARCH_DUTY), 1'b1);
                right_req_s = mk_drive(8'(SEARCH_DUTY), 1'b0);
            end
            ST_TURN_L: begin
                left_req_s  = mk_drive(8'(TURN_DUTY), 1'b0);
                right_req_s = mk_drive(8'(TURN_DUTY), 1'b1);
            end
            ST_TURN_R: begin
                left_req_s  = mk_drive(8'(TURN_DUTY), 1'b1);
                right_req_s = mk_drive(8'(TURN_DUTY), 1'b0);
            end
            ST_FWD: begin
                left_req_s  = mk_drive(fwd_duty_s, 1'b1);
                right_req_s = mk_drive(fwd_duty_s, 1'b1);
            end
            default: begin
                left_req_s  = mk_drive(8'd0, 1'b1);
                right_req_s = mk_drive(8'd0, 1'b1);
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
            x_q       <= 11'd0;
            r_q       <= 24'd0;
            ok_q      <= 1'b0;
            half_q    <= 1'b0;
            lost_q    <= '0;
            state_q   <= ST_STOP;
        end else begin
            vs_meta_q <= vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            tick_q    <= tick_d;
            x_q       <= x_d;
            r_q       <= r_d;
            ok_q      <= ok_d;
            half_q    <= half_d;
            lost_q    <= lost_d;
            state_q   <= state_d;
        end
    end

    pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm_left (
        .clk        (clk),
        .reset      (reset),
        .sync_clear (~enable),
        .req        (left_req_s),
        .pwm        (left_pwm),
        .dir        (left_dir)
    );

    pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm_right (
        .clk        (clk),
        .reset      (reset),
        .sync_clear (~enable),
        .req        (right_req_s),
        .pwm        (right_pwm),
        .dir        (right_dir)
    );

    assign state      = state_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_chase_drive.sv
// Self-checking bench for chase_drive with a frame-level behavioural model of the drive mode.
module tb_chase_drive;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic [31:0] x_center = 32'd0;
    logic [23:0] radius = 24'd0;
    logic        enable = 1'b1;
    logic        left_pwm, right_pwm, left_dir, right_dir, frame_tick;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    int m_state = 0;
    int m_lost = 0;

    chase_drive #(.PWM_DIV(1)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .x_center(x_center), .radius(radius),
        .enable(enable), .left_pwm(left_pwm), .right_pwm(right_pwm), .left_dir(left_dir),
        .right_dir(right_dir), .state(state), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Model of one frame decision, straight from the mode rules.
    task automatic model_frame(input logic [31:0] x, input logic [23:0] r);
        bit ok;
        ok = (r >= 24'd4) && (x < 32'd1024);
        m_lost = ok ? 0 : ((m_lost < 15) ? m_lost + 1 : 15);
        if (!enable) m_state = 0;
        else if (ok && r >= 24'd80) m_state = 5;
        else if (ok && x < 32'd448) m_state = 2;
        else if (ok && x > 32'd575) m_state = 3;
        else if (ok) m_state = 4;
        else if (m_lost == 15) m_state = 1;
    endtask

    task automatic do_frame(input logic [31:0] x, input logic [23:0] r, output int lat);
        x_center = x;
        radius   = r;
        vsync    = 1'b1;
        repeat (4) @(posedge clk);
        #1 vsync = 1'b0;
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (frame_tick === 1'b1) break;
        end
        if (frame_tick !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_wait: frame_tick=%b after %0d clocks, required 1", frame_tick, lat);
        end
        model_frame(x, r);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Count high cycles over exactly one PWM period (512 clocks) once the duty has settled.
    task automatic measure(output int hl, output int hr, output logic dl, output logic dr);
        repeat (1100) @(posedge clk);
        #1;
        hl = 0;
        hr = 0;
        repeat (512) begin
            @(posedge clk);
            #1;
            hl += int'(left_pwm);
            hr += int'(right_pwm);
        end
        dl = left_dir;
        dr = right_dir;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({state, left_pwm, right_pwm, left_dir, right_dir, frame_tick} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: state=%0d lp=%b rp=%b ld=%b rd=%b ft=%b, required all 0",
                     state, left_pwm, right_pwm, left_dir, right_dir, frame_tick);
        end
        reset = 1'b0;
        m_state = 0;
        m_lost = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_search;
        int lat, hl, hr;
        logic dl, dr;
        for (int i = 1; i <= 15; i++) begin
            do_frame(32'd512, 24'd0, lat);
            if (i == 3 || i == 14) begin
                n_cmp++;
                if (state !== 3'd0) begin
                    n_bad++;
                    $display("FAIL stop_hold_f%0d: state=%0d, required 0", i, state);
                end
            end
        end
        n_cmp++;
        if (state !== 3'd1) begin
            n_bad++;
            $display("FAIL search_entry: state=%0d, required 1", state);
        end
        measure(hl, hr, dl, dr);
        n_cmp++;
        if (hl !== 192 || hr !== 192 || dl !== 1'b1 || dr !== 1'b0) begin
            n_bad++;
            $display("FAIL search_drive: high %0d/%0d dir %b/%b, required 192/192 dir 1/0", hl, hr, dl, dr);
        end
    endtask

    task automatic test_turn_l;
        int lat, hl, hr;
        logic dl, dr;
        do_frame(32'd300, 24'd20, lat);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL tick_latency: %0d clocks, required 3", lat);
        end
        n_cmp++;
        if (state !== 3'd2) begin
            n_bad++;
            $display("FAIL turn_l_state: state=%0d, required 2", state);
        end
        measure(hl, hr, dl, dr);
        n_cmp++;
        if (hl !== 256 || hr !== 256 || dl !== 1'b0 || dr !== 1'b1) begin
            n_bad++;
            $display("FAIL turn_l_drive: high %0d/%0d dir %b/%b, required 256/256 dir 0/1", hl, hr, dl, dr);
        end
    endtask

    task automatic test_fwd;
        int lat, hl, hr, run, bad_runs, seen;
        logic dl, dr, prev, started;
        do_frame(32'd512, 24'd20, lat);
        measure(hl, hr, dl, dr);
        n_cmp++;
        if (state !== 3'd4 || hl !== 448 || hr !== 448 || dl !== 1'b1 || dr !== 1'b1) begin
            n_bad++;
            $display("FAIL fwd_full: state=%0d high %0d/%0d dir %b/%b, required 4 448/448 dir 1/1",
                     state, hl, hr, dl, dr);
        end
        do_frame(32'd512, 24'd50, lat);
        run = 0; bad_runs = 0; seen = 0; started = 1'b0; prev = left_pwm;
        repeat (1600) begin
            @(posedge clk);
            #1;
            if (left_pwm) begin
                run++;
            end else begin
                if (prev && started) begin
                    seen++;
                    if (run != 448 && run != 224) bad_runs++;
                end
                run = 0;
                started = 1'b1;
            end
            prev = left_pwm;
        end
        n_cmp++;
        if (bad_runs !== 0 || seen < 2) begin
            n_bad++;
            $display("FAIL fwd_glitch: %0d odd pulses of %0d, required 0 of at least 2", bad_runs, seen);
        end
        measure(hl, hr, dl, dr);
        n_cmp++;
        if (hl !== 224 || hr !== 224) begin
            n_bad++;
            $display("FAIL fwd_half: high %0d/%0d, required 224/224", hl, hr);
        end
    endtask

    task automatic test_hold;
        int lat, hl, hr;
        logic dl, dr;
        do_frame(32'd900, 24'd80, lat);
        measure(hl, hr, dl, dr);
        n_cmp++;
        if (state !== 3'd5 || hl !== 0 || hr !== 0) begin
            n_bad++;
            $display("FAIL hold: state=%0d high %0d/%0d, required 5 0/0", state, hl, hr);
        end
    endtask

    task automatic test_lost;
        int lat;
        do_frame(32'd800, 24'd20, lat);
        do_frame(32'd800, 24'd2, lat);
        n_cmp++;
        if (state !== 3'd3) begin
            n_bad++;
            $display("FAIL lost_keep_turn_r: state=%0d, required 3", state);
        end
        do_frame(32'd512, 24'd20, lat);
        n_cmp++;
        if (state !== 3'd4) begin
            n_bad++;
            $display("FAIL lost_recover_fwd: state=%0d, required 4", state);
        end
        for (int i = 1; i <= 15; i++) begin
            do_frame(32'd512, 24'd1, lat);
            if (i == 14) begin
                n_cmp++;
                if (state !== 3'd4) begin
                    n_bad++;
                    $display("FAIL lost_cleared: state=%0d after 14 misses, required 4", state);
                end
            end
        end
        n_cmp++;
        if (state !== 3'd1) begin
            n_bad++;
            $display("FAIL lost_to_search: state=%0d, required 1", state);
        end
    endtask

    task automatic test_enable_stop;
        int lat, w;
        do_frame(32'd512, 24'd20, lat);
        w = 0;
        while (left_pwm !== 1'b1 && w < 1200) begin
            @(posedge clk);
            #1;
            w++;
        end
        n_cmp++;
        if (left_pwm !== 1'b1) begin
            n_bad++;
            $display("FAIL en_wait_pwm: left_pwm=%b, required 1", left_pwm);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        m_state = 0;
        n_cmp++;
        if (left_pwm !== 1'b0 || right_pwm !== 1'b0 || state !== 3'd0) begin
            n_bad++;
            $display("FAIL enable_stop: lp=%b rp=%b state=%0d, required 0 0 0", left_pwm, right_pwm, state);
        end
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
    endtask

    task automatic test_reset_mid;
        int lat, w;
        do_frame(32'd512, 24'd20, lat);
        w = 0;
        while (right_pwm !== 1'b1 && w < 1200) begin
            @(posedge clk);
            #1;
            w++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({state, left_pwm, right_pwm, left_dir, right_dir, frame_tick} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid: state=%0d lp=%b rp=%b ld=%b rd=%b ft=%b, required all 0",
                     state, left_pwm, right_pwm, left_dir, right_dir, frame_tick);
        end
        reset = 1'b0;
        m_state = 0;
        m_lost = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int lat;
        int xb[6] = '{447, 448, 575, 576, 1023, 1024};
        int rb[6] = '{3, 4, 39, 40, 79, 80};
        logic [31:0] x;
        logic [23:0] r;
        logic [2:0] es;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: x = 32'($urandom_range(0, 1023));
                1: x = 32'(xb[$urandom_range(0, 5)]);
                2: x = 32'h8000_0000 | 32'($urandom_range(0, 1023));
                default: x = 32'($urandom_range(0, 1200));
            endcase
            case ($urandom_range(0, 3))
                0: r = 24'(rb[$urandom_range(0, 5)]);
                1: r = 24'h80_0000 | 24'($urandom_range(0, 3));
                default: r = 24'($urandom_range(0, 120));
            endcase
            enable = ($urandom_range(0, 9) != 0);
            do_frame(x, r, lat);
            es = m_state[2:0];
            n_cmp++;
            if (state !== es) begin
                n_bad++;
                $display("FAIL random_f%0d: x=%0h r=%0h state=%0d, required %0d", i, x, r, state, es);
            end
            enable = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_search();
        test_turn_l();
        test_fwd();
        test_hold();
        test_lost();
        test_enable_stop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
